// File: rtl/omem_access_arbiter.sv
// Round-robin arbiter sharing the single-port OMEM among the sum PEs, plus timestep sequencing.
// Optional per-requester stall counters are enabled with `define OMEM_STALL_CNT_EN.
module omem_access_arbiter #(
    parameter int NUM_REQ   = 5,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 14,
    parameter int OUT_COUNT = 400,
    parameter int NUM_TS    = 2,
    parameter int TS_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [TS_W-1:0]             ts,
    output logic                        ts_done,
    output logic                        all_done,
`ifdef OMEM_STALL_CNT_EN
    output logic                        err_addr,
    output logic [NUM_REQ*16-1:0]       stall_cnt
`else
    output logic                        err_addr
`endif
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WCNT_W = $clog2(OUT_COUNT + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_TS_END = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [WCNT_W-1:0]   wcnt;

    logic [NUM_REQ-1:0]  gnt;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                in_range;
    logic                mem_acc;
    logic                rd_zero;
    logic                cnt_wr;

    logic [NUM_REQ-1:0]  vld_p0;
    logic                zero_p0;
    logic [NUM_REQ-1:0]  vld_p1;
    logic                zero_p1;

    // Round-robin search from the pointer; grants only while running
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (state == S_RUN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!gnt_any && req_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PTR_W'(idx);
                end
            end
            if (gnt_any) begin
                gnt[gnt_idx] = 1'b1;
            end
        end
    end

    assign req_ready = gnt;

    always_comb begin
        sel_write = req_write[gnt_idx];
        sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        in_range  = (32'(sel_addr) < 32'(OUT_COUNT));
        // Timestep 0 has no residual potential, so its reads never touch OMEM
        rd_zero   = !in_range || (ts == '0);
        mem_acc   = gnt_any && in_range && (sel_write || (ts != '0));
        cnt_wr    = gnt_any && sel_write && in_range;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (cnt_wr && (wcnt == WCNT_W'(OUT_COUNT - 1))) begin
                    state_nxt = S_TS_END;
                end
            end
            S_TS_END: begin
                if (ts == TS_W'(NUM_TS - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RUN;
            rr_ptr   <= '0;
            wcnt     <= '0;
            ts       <= '0;
            err_addr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_TS_END) begin
                wcnt <= '0;
                ts   <= ts + TS_W'(1);
            end else if (cnt_wr) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
            if (gnt_any) begin
                rr_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            if (gnt_any && !in_range) begin
                err_addr <= 1'b1;
            end
        end
    end

    // Stage p0: registered OMEM command, read tag travels alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vld_p0    <= '0;
            zero_p0   <= 1'b0;
        end else begin
            mem_en  <= mem_acc;
            mem_we  <= mem_acc && sel_write;
            if (mem_acc) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            vld_p0  <= (gnt_any && !sel_write) ? gnt : '0;
            zero_p0 <= rd_zero;
        end
    end

    // Stage p1: OMEM read data arrives; response strobe aligned with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= '0;
            zero_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            zero_p1 <= zero_p0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_data  = ((|vld_p1) && !zero_p1) ? mem_rdata : '0;
    assign ts_done   = (state == S_TS_END);
    assign all_done  = (state == S_DONE);

`ifdef OMEM_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !gnt[i]) begin
                    stall_cnt[i*16 +: 16] <= sat_inc(stall_cnt[i*16 +: 16]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_omem_access_arbiter.sv
// Bench for omem_access_arbiter: directed phases plus random traffic against a transaction-level model.
module tb_omem_access_arbiter;

    localparam int NUM_REQ   = 5;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 14;
    localparam int OUT_COUNT = 400;
    localparam int NUM_TS    = 2;
    localparam int TS_W      = 4;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic [TS_W-1:0]           ts;
    logic                      ts_done;
    logic                      all_done;
    logic                      err_addr;
`ifdef OMEM_STALL_CNT_EN
    logic [NUM_REQ*16-1:0]     stall_cnt;
`endif

    omem_access_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .OUT_COUNT(OUT_COUNT), .NUM_TS(NUM_TS), .TS_W(TS_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ts(ts), .ts_done(ts_done), .all_done(all_done),
`ifdef OMEM_STALL_CNT_EN
        .err_addr(err_addr), .stall_cnt(stall_cnt)
`else
        .err_addr(err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // OMEM device: single port, one-cycle read latency
    logic [DATA_W-1:0] dev [0:511] = '{default: 14'h155};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dev[mem_addr] <= mem_wdata;
            else        mem_rdata     <= dev[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Requester stimulus
    bit                v [NUM_REQ];
    bit                w [NUM_REQ];
    logic [ADDR_W-1:0] a [NUM_REQ];
    logic [DATA_W-1:0] d [NUM_REQ];
    int                mode;

    // Reference model
    logic [DATA_W-1:0] sh [0:511];
    int                m_ptr, m_ts, m_wcnt;
    bit                m_bnd, m_done, m_err;
    bit                e_en, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd, e_rd, p_rd;
    logic [NUM_REQ-1:0] e_rv, p_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_ptr = 0; m_ts = 0; m_wcnt = 0;
        m_bnd = 0; m_done = 0; m_err = 0;
        e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
        e_rv = '0; p_rv = '0; e_rd = '0; p_rd = '0;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = v[i];
            req_write[i] = w[i];
            req_addr[i*ADDR_W +: ADDR_W]  = a[i];
            req_wdata[i*DATA_W +: DATA_W] = d[i];
        end
    endtask

    task automatic new_req(input int i);
        if (mode == 0) begin
            v[i] = 0;
        end else if (mode == 1) begin
            v[i] = ($urandom_range(0, 9) < 7);
            w[i] = ($urandom_range(0, 9) < 8);
            a[i] = ADDR_W'($urandom_range(0, OUT_COUNT - 1));
            if (a[i] == 9'd7) a[i] = 9'd8;
            d[i] = DATA_W'($urandom);
        end else begin
            v[i] = 1; w[i] = 0;
            a[i] = ADDR_W'($urandom_range(0, OUT_COUNT - 1));
            d[i] = '0;
        end
    endtask

    // One clock: called mid-cycle (negedge), checks outputs, advances model, returns at next negedge
    task automatic cycle();
        int g;
        bit inr;
        logic [NUM_REQ-1:0] exp_rdy;
        apply_inputs();
        #1;
        chk("ts", 32'(ts), 32'(m_ts));
        chk("ts_done", 32'(ts_done), 32'(m_bnd));
        chk("all_done", 32'(all_done), 32'(m_done));
        chk("err_addr", 32'(err_addr), 32'(m_err));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv != 0) chk("rsp_data", 32'(rsp_data), 32'(e_rd));
        g = -1;
        if (!m_bnd && !m_done) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        exp_rdy = (g >= 0) ? NUM_REQ'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));

        e_rv = p_rv; e_rd = p_rd; p_rv = '0; p_rd = '0;
        e_en = 0; e_we = 0;
        if (m_bnd) begin
            m_bnd = 0; m_ts++; m_wcnt = 0;
            if (m_ts == NUM_TS) m_done = 1;
        end
        if (g >= 0) begin
            inr = (int'(a[g]) < OUT_COUNT);
            if (!inr) m_err = 1;
            if (w[g]) begin
                if (inr) begin
                    e_en = 1; e_we = 1; e_addr = a[g]; e_wd = d[g];
                    sh[a[g]] = d[g];
                    m_wcnt++;
                    if (m_wcnt == OUT_COUNT) m_bnd = 1;
                end
            end else begin
                p_rv = NUM_REQ'(1 << g);
                p_rd = (inr && m_ts != 0) ? sh[a[g]] : '0;
                if (inr && m_ts != 0) begin
                    e_en = 1; e_we = 0; e_addr = a[g];
                end
            end
            m_ptr = (g + 1) % NUM_REQ;
            new_req(g);
        end
        if (mode == 1) begin
            for (int i = 0; i < NUM_REQ; i++) if (!v[i]) new_req(i);
        end
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_ts"}, 32'(ts), 0);
        chk({tag, "_ts_done"}, 32'(ts_done), 0);
        chk({tag, "_all_done"}, 32'(all_done), 0);
        chk({tag, "_err_addr"}, 32'(err_addr), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = 0; w[i] = 0; a[i] = '0; d[i] = '0;
        end
        apply_inputs();
        reset_model();
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("rst");
        rst_n = 1'b1;
    endtask

    task automatic run_until_ts(input int target, input int budget);
        int n;
        n = 0;
        while (m_ts < target && !m_done && n < budget) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 512; i++) sh[i] = 14'h155;
        do_reset();

        // Timestep 0 single read: zero data, no OMEM access
        v[2] = 1; w[2] = 0; a[2] = 9'd5;
        repeat (4) cycle();

        // All requesters reading: rotation 0..4,0 with responses in order
        do_reset();
        mode = 2;
        for (int i = 0; i < NUM_REQ; i++) new_req(i);
        repeat (8) cycle();

        // Timestep 0 fill with known value at addr 7, then random traffic to the boundary
        do_reset();
        v[0] = 1; w[0] = 1; a[0] = 9'd7; d[0] = 14'h0A3;
        cycle();
        mode = 1;
        run_until_ts(1, 4000);
        chk("ts_reached_1", 32'(ts), 1);

        // Drain, then a timestep 1 read of addr 7
        mode = 0;
        for (int n = 0; n < 60; n++) if (v[0] | v[1] | v[2] | v[3] | v[4]) cycle();
        v[0] = 1; w[0] = 0; a[0] = 9'd7;
        repeat (4) cycle();

        // Second timestep to completion, then requests must stay blocked
        mode = 1;
        run_until_ts(NUM_TS, 4000);
        repeat (3) cycle();
        chk("all_done_reached", 32'(all_done), 1);
        repeat (10) cycle();

        // Out-of-range write and read, then the count must still need 400 in-range writes
        do_reset();
        v[1] = 1; w[1] = 1; a[1] = 9'd400; d[1] = 14'h3FFF;
        v[4] = 1; w[4] = 0; a[4] = 9'h1FF;
        repeat (4) cycle();
        mode = 1;
        run_until_ts(1, 4000);
        chk("err_ts_reached_1", 32'(ts), 1);
        chk("err_addr_sticky", 32'(err_addr), 1);

        // Reset one cycle after a read grant: the response must never appear
        do_reset();
        v[3] = 1; w[3] = 0; a[3] = 9'd10;
        cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid_a", 32'(rsp_valid), 0);
        chk("midrst_mem_en", 32'(mem_en), 0);
        @(negedge clk);
        #1;
        chk("midrst_rsp_valid_b", 32'(rsp_valid), 0);
        chk("midrst_ts", 32'(ts), 0);
        do_reset();
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
